// File: rtl/control_sequencer_if.sv
// control_sequencer_if
// Groups the sequencer's step/control signals into one bundle.
//   master : drives clk_en, prog_mode, opcode, flag_c, flag_z;
//            observes ctrl_word, tstate, halted, instr_done
//   slave  : the sequencer side (mirror of master)
interface control_sequencer_if;
    logic        clk_en;
    logic        prog_mode;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl_word;
    logic [2:0]  tstate;
    logic        halted;
    logic        instr_done;

    modport master (
        output clk_en, prog_mode, opcode, flag_c, flag_z,
        input  ctrl_word, tstate, halted, instr_done
    );

    modport slave (
        input  clk_en, prog_mode, opcode, flag_c, flag_z,
        output ctrl_word, tstate, halted, instr_done
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
// Microcode sequencer for an 8-bit breadboard-style CPU. Steps through
// microsteps T0..T4 per instruction and decodes the 16-bit control word
// from (tstate, opcode, flags).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : control_sequencer_if.slave
//           in : clk_en (step enable), prog_mode (RAM programming request),
//                opcode[3:0], flag_c, flag_z
//           out: ctrl_word[15:0] (HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI),
//                tstate[2:0], halted, instr_done (one-clk pulse on return to T0)
// Parameter:
//   SKIP_IDLE : 1 = cut an instruction short once its remaining steps are all zero
module control_sequencer #(
    parameter int SKIP_IDLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    control_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_PROG = 2'd2
    } state_t;

    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state_q, state_d;
    logic [2:0] tstate_q, tstate_d;
    logic       done_q, done_d;

    // Microcode ROM: control word for a given step, opcode and flag set.
    function automatic logic [15:0] step_word(input logic [2:0] t,
                                              input logic [3:0] op,
                                              input logic       c,
                                              input logic       z);
        logic [15:0] w;
        w = 16'h0000;
        case (t)
            3'd0: w = 16'h4004;                   // CO|MI
            3'd1: w = 16'h1408;                   // RO|II|CE
            3'd2: begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4: w = 16'h4800;   // IO|MI
                    4'h5: w = 16'h0A00;                     // IO|AI
                    4'h6: w = 16'h0802;                     // IO|J
                    4'h7: w = c ? 16'h0802 : 16'h0000;
                    4'h8: w = z ? 16'h0802 : 16'h0000;
                    4'hE: w = 16'h0110;                     // AO|OI
                    4'hF: w = 16'h8000;                     // HLT
                    default: w = 16'h0000;
                endcase
            end
            3'd3: begin
                case (op)
                    4'h1: w = 16'h1200;                     // RO|AI
                    4'h2, 4'h3: w = 16'h1020;               // RO|BI
                    4'h4: w = 16'h2100;                     // AO|RI
                    default: w = 16'h0000;
                endcase
            end
            3'd4: begin
                case (op)
                    4'h2: w = 16'h0281;                     // EO|AI|FI
                    4'h3: w = 16'h02C1;                     // EO|AI|SU|FI
                    default: w = 16'h0000;
                endcase
            end
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Next step after Tn (n = 2,3): early return to T0 when the following
    // word is empty and skipping is enabled.
    function automatic logic skip_after(input logic [2:0] t,
                                        input logic [3:0] op,
                                        input logic       c,
                                        input logic       z);
        return (SKIP_IDLE != 0) && (step_word(t + 3'd1, op, c, z) == 16'h0000);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            tstate_q <= 3'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tstate_q <= tstate_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tstate_d = tstate_q;
        done_d   = 1'b0;
        if (bus.prog_mode) begin
            // Programming request wins regardless of clk_en, even mid-instruction.
            state_d  = ST_PROG;
            tstate_d = 3'd0;
        end else begin
            case (state_q)
                ST_PROG: begin
                    state_d  = ST_RUN;
                    tstate_d = 3'd0;
                end
                ST_HALT: begin
                    state_d  = ST_HALT;
                    tstate_d = 3'd0;
                end
                default: begin
                    if (bus.clk_en) begin
                        case (tstate_q)
                            3'd0: tstate_d = 3'd1;
                            3'd1: tstate_d = 3'd2;
                            3'd2: begin
                                if (bus.opcode == OP_HLT) begin
                                    state_d  = ST_HALT;
                                    tstate_d = 3'd0;
                                end else if (skip_after(3'd2, bus.opcode, bus.flag_c, bus.flag_z)) begin
                                    tstate_d = 3'd0;
                                    done_d   = 1'b1;
                                end else begin
                                    tstate_d = 3'd3;
                                end
                            end
                            3'd3: begin
                                if (skip_after(3'd3, bus.opcode, bus.flag_c, bus.flag_z)) begin
                                    tstate_d = 3'd0;
                                    done_d   = 1'b1;
                                end else begin
                                    tstate_d = 3'd4;
                                end
                            end
                            default: begin
                                tstate_d = 3'd0;
                                done_d   = 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // ctrl_word is forced quiet during reset, programming and halt so no
    // partial step ever reaches the datapath.
    always_comb begin
        bus.ctrl_word = 16'h0000;
        if (rst_n && !bus.prog_mode && state_q == ST_RUN)
            bus.ctrl_word = step_word(tstate_q, bus.opcode, bus.flag_c, bus.flag_z);
    end

    assign bus.tstate     = tstate_q;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.instr_done = done_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter SKIP_IDLE, default 1: 1 = end an instruction early when its remaining microsteps are all-zero; 0 = always run T0..T4.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port clk_en, input, 1, step enable; the microstep advances only on clk edges where clk_en=1.
REQ-005 The block SHALL have port prog_mode, input, 1, RAM-programming request; it takes priority over everything except reset.
REQ-006 The block SHALL have port opcode, input, 4, the instruction register's upper nibble.
REQ-007 The block SHALL have ports flag_c and flag_z, inputs, 1 each, the carry and zero flags from the flags register.
REQ-008 The block SHALL have port ctrl_word, output, 16, with bits 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
REQ-009 The block SHALL have port tstate, output, 3, the current microstep (0..4).
REQ-010 The block SHALL have port halted, output, 1, high while in state HALT.
REQ-011 The block SHALL have port instr_done, output, 1, a one-clk pulse on the edge where the step returns to T0 from RUN.

Function
REQ-012 The block SHALL implement states RUN, HALT and PROG.
REQ-013 In RUN, ctrl_word SHALL be a combinational decode of (tstate, opcode, flag_c, flag_z), valid for the whole step; the datapath captures on the step-ending edge.
REQ-014 The fetch steps SHALL be T0 = CO|MI (0x4004) and T1 = RO|II|CE (0x1408) for every opcode.
REQ-015 Steps T2/T3/T4 SHALL be as follows:
- LDA 0001: 0x4800 / 0x1200 / 0
- ADD 0010: 0x4800 / 0x1020 / 0x0281
- SUB 0011: 0x4800 / 0x1020 / 0x02C1
- STA 0100: 0x4800 / 0x2100 / 0
- LDI 0101: 0x0A00 / 0 / 0
- JMP 0110: 0x0802 / 0 / 0
- JC 0111: 0x0802 if flag_c else 0; then 0 / 0
- JZ 1000: same as JC using flag_z
- OUT 1110: 0x0110 / 0 / 0
- HLT 1111: 0x8000 / 0 / 0
- NOP 0000 and 1001-1101: all zero
REQ-016 On a RUN edge with clk_en=1, T0->T1->T2 SHALL always advance, and T4 SHALL go to T0.
REQ-017 When SKIP_IDLE=1, at the end of Tn (n=2,3) the next step SHALL be T0 if the T(n+1) word for the current opcode and flags is zero, otherwise T(n+1). NOP and a not-taken JC/JZ therefore take 3 steps.
REQ-018 When SKIP_IDLE=0, every instruction SHALL take 5 steps.
REQ-019 instr_done SHALL be 1 for exactly one clk after each transition into T0 from RUN, and 0 otherwise.
REQ-020 At the end of a T2 step with opcode 1111, the block SHALL enter HALT with tstate=0.
REQ-021 In HALT, ctrl_word SHALL be 0, halted SHALL be 1, and clk_en SHALL be ignored; HALT exits only via reset or prog_mode.
REQ-022 prog_mode=1 SHALL be sampled on every clk regardless of clk_en and SHALL move RUN or HALT to PROG with tstate=0 on the next edge, even mid-instruction.
REQ-023 ctrl_word SHALL be 0 combinationally whenever prog_mode=1 or state=PROG.
REQ-024 On the first edge with prog_mode=0, PROG SHALL go to RUN at T0; instr_done SHALL not pulse on that edge.
REQ-025 With clk_en=0 in RUN, tstate and ctrl_word SHALL hold, given stable opcode and flags.
REQ-026 opcode and flags changes SHALL affect only the combinational ctrl_word and the skip decision; no other state.

Reset
REQ-027 While rst_n=0, outputs SHALL be, asynchronously: state RUN, tstate=0, halted=0, instr_done=0, ctrl_word=0.
REQ-028 After rst_n rises, ctrl_word SHALL show 0x4004 (T0), and the first clk_en edge SHALL advance to T1.
REQ-029 A reset mid-instruction SHALL abandon the instruction with no partial-step output.

Verification
REQ-030 Scenario: reset, clk_en=1, opcode=0101 -> ctrl_word 0x4004, 0x1408, 0x0A00, then 0x4004; instr_done pulses once; tstate 0,1,2,0.
REQ-031 Scenario: opcode=0111 with flag_c=0 -> T2 0x0000, then T0; repeat with flag_c=1 -> T2 0x0802, then T0.
REQ-032 Scenario: opcode=0010 -> 0x4004, 0x1408, 0x4800, 0x1020, 0x0281, then T0; with SKIP_IDLE=0, LDI shows 0x0A00, 0, 0 over T2-T4.
REQ-033 Scenario: opcode=1111 -> T2 0x8000, then halted=1, ctrl_word=0 through 10 clk_en pulses; prog_mode=1 -> PROG, halted=0; prog_mode=0 -> 0x4004.
REQ-034 Scenario: ADD at T3 with clk_en held 0 for 5 clks -> 0x1020 held; then assert rst_n=0 -> ctrl_word=0 and tstate=0 immediately; release -> 0x4004.
REQ-035 Scenario: prog_mode=1 during STA T3 -> ctrl_word=0 the same cycle, PROG next edge, no instr_done pulse.
